// File: rtl/vpu_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// vpu_issue_ctrl_if
// Decoded-request channel from the VPU decoder to the issue controller.
//   master : decoder side, drives req_valid and the request fields
//   slave  : issue controller side, drives req_ready
// Fields:
//   req_valid / req_ready : handshake, transfer when both high
//   req_raddr             : source addresses, port k at [k*ADDR_W +: ADDR_W]
//   req_rvalid            : active-source mask
//   req_waddr             : destination address
//   req_delay             : execution latency in cycles (0 treated as 1)
//   req_op_func           : packed exec request
//   req_opcode            : opcode, 0 means NOP
// ----------------------------------------------------------------------------
interface vpu_issue_ctrl_if #(
    parameter int unsigned SRAM_R_PORT_CNT = 3,
    parameter int unsigned ADDR_W          = 8,
    parameter int unsigned MAX_DELAY_LG2   = 4,
    parameter int unsigned OPCODE_W        = 5,
    parameter int unsigned OPFUNC_W        = 16
);
    logic                                req_valid;
    logic                                req_ready;
    logic [SRAM_R_PORT_CNT*ADDR_W-1:0]   req_raddr;
    logic [SRAM_R_PORT_CNT-1:0]          req_rvalid;
    logic [ADDR_W-1:0]                   req_waddr;
    logic [MAX_DELAY_LG2-1:0]            req_delay;
    logic [OPFUNC_W-1:0]                 req_op_func;
    logic [OPCODE_W-1:0]                 req_opcode;

    modport master (
        output req_valid,
        output req_raddr,
        output req_rvalid,
        output req_waddr,
        output req_delay,
        output req_op_func,
        output req_opcode,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_raddr,
        input  req_rvalid,
        input  req_waddr,
        input  req_delay,
        input  req_op_func,
        input  req_opcode,
        output req_ready
    );
endinterface

// File: rtl/vpu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// vpu_issue_ctrl
// Single-issue, non-pipelined sequencer between the VPU decoder and the
// SRAM / execution datapath. Accepts one decoded request, reads the active
// source operands, launches the execution lane, waits the decoded delay and
// writes the lane result back to SRAM.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req           : decoded-request channel (slave side)
//   sram_ren/raddr/rdata       : SRAM read ports
//   exec_start/op_func/opcode/operand, exec_result : execution lane
//   sram_wen/waddr/wdata       : SRAM write port
//   busy, done    : request in flight, completion pulse (with sram_wen)
// Control outputs are registered. exec_operand and sram_wdata are gated
// pass-throughs of sram_rdata / exec_result because that data only becomes
// valid in the cycle it is consumed; their gates are registered.
// ----------------------------------------------------------------------------
module vpu_issue_ctrl #(
    parameter int unsigned SRAM_R_PORT_CNT = 3,
    parameter int unsigned ADDR_W          = 8,
    parameter int unsigned DATA_W          = 256,
    parameter int unsigned MAX_DELAY_LG2   = 4,
    parameter int unsigned OPCODE_W        = 5,
    parameter int unsigned OPFUNC_W        = 16,
    parameter int unsigned SRAM_RD_LAT     = 1   // must be >= 1
) (
    input  logic                                clk,
    input  logic                                rst,

    vpu_issue_ctrl_if.slave                     req,

    output logic [SRAM_R_PORT_CNT-1:0]          sram_ren,
    output logic [SRAM_R_PORT_CNT*ADDR_W-1:0]   sram_raddr,
    input  logic [SRAM_R_PORT_CNT*DATA_W-1:0]   sram_rdata,

    output logic                                exec_start,
    output logic [OPFUNC_W-1:0]                 exec_op_func,
    output logic [OPCODE_W-1:0]                 exec_opcode,
    output logic [SRAM_R_PORT_CNT*DATA_W-1:0]   exec_operand,
    input  logic [DATA_W-1:0]                   exec_result,

    output logic                                sram_wen,
    output logic [ADDR_W-1:0]                   sram_waddr,
    output logic [DATA_W-1:0]                   sram_wdata,

    output logic                                busy,
    output logic                                done
);

    localparam int unsigned RADDR_W    = SRAM_R_PORT_CNT * ADDR_W;
    // RWAIT counts down from SRAM_RD_LAT-2 to 0, i.e. SRAM_RD_LAT-1 cycles
    localparam int unsigned RWAIT_W    = (SRAM_RD_LAT > 2) ? $clog2(SRAM_RD_LAT - 1) : 1;
    localparam int unsigned RWAIT_LOAD = (SRAM_RD_LAT > 1) ? (SRAM_RD_LAT - 2) : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RWAIT,
        S_EXEC,
        S_WR
    } state_e;

    typedef struct packed {
        logic [RADDR_W-1:0]         raddr;
        logic [SRAM_R_PORT_CNT-1:0] rvalid;
        logic [ADDR_W-1:0]          waddr;
        logic [MAX_DELAY_LG2-1:0]   delay;
        logic [OPFUNC_W-1:0]        op_func;
        logic [OPCODE_W-1:0]        opcode;
    } req_t;

    state_e                      state_q,      state_d;
    req_t                        req_q,        req_d;
    logic [RWAIT_W-1:0]          rwait_cnt_q,  rwait_cnt_d;
    logic [MAX_DELAY_LG2-1:0]    exec_cnt_q,   exec_cnt_d;

    logic                        req_ready_q,    req_ready_d;
    logic                        busy_q,         busy_d;
    logic [SRAM_R_PORT_CNT-1:0]  sram_ren_q,     sram_ren_d;
    logic [RADDR_W-1:0]          sram_raddr_q,   sram_raddr_d;
    logic                        exec_start_q,   exec_start_d;
    logic [OPFUNC_W-1:0]         exec_op_func_q, exec_op_func_d;
    logic [OPCODE_W-1:0]         exec_opcode_q,  exec_opcode_d;
    logic                        sram_wen_q,     sram_wen_d;
    logic [ADDR_W-1:0]           sram_waddr_q,   sram_waddr_d;
    logic                        done_q,         done_d;

    // EXEC down-counter load value: max(delay,1) - 1
    function automatic logic [MAX_DELAY_LG2-1:0] exec_load(input logic [MAX_DELAY_LG2-1:0] dly);
        return (dly == '0) ? '0 : (dly - MAX_DELAY_LG2'(1));
    endfunction

    // State register, latched request, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            req_q          <= '0;
            rwait_cnt_q    <= '0;
            exec_cnt_q     <= '0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            sram_ren_q     <= '0;
            sram_raddr_q   <= '0;
            exec_start_q   <= 1'b0;
            exec_op_func_q <= '0;
            exec_opcode_q  <= '0;
            sram_wen_q     <= 1'b0;
            sram_waddr_q   <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            rwait_cnt_q    <= rwait_cnt_d;
            exec_cnt_q     <= exec_cnt_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
            sram_ren_q     <= sram_ren_d;
            sram_raddr_q   <= sram_raddr_d;
            exec_start_q   <= exec_start_d;
            exec_op_func_q <= exec_op_func_d;
            exec_opcode_q  <= exec_opcode_d;
            sram_wen_q     <= sram_wen_d;
            sram_waddr_q   <= sram_waddr_d;
            done_q         <= done_d;
        end
    end

    // Next state, request capture, counters, and next-cycle output values
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        rwait_cnt_d    = rwait_cnt_q;
        exec_cnt_d     = exec_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // req_ready is high exactly in IDLE, so valid alone is the handshake
                if (req.req_valid) begin
                    req_d.raddr   = req.req_raddr;
                    req_d.rvalid  = req.req_rvalid;
                    req_d.waddr   = req.req_waddr;
                    req_d.delay   = req.req_delay;
                    req_d.op_func = req.req_op_func;
                    req_d.opcode  = req.req_opcode;
                    if (req.req_opcode != '0) begin
                        if (req.req_rvalid == '0) begin
                            state_d    = S_EXEC;
                            exec_cnt_d = exec_load(req.req_delay);
                        end else begin
                            state_d    = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                if (SRAM_RD_LAT > 1) begin
                    state_d     = S_RWAIT;
                    rwait_cnt_d = RWAIT_W'(RWAIT_LOAD);
                end else begin
                    state_d     = S_EXEC;
                    exec_cnt_d  = exec_load(req_q.delay);
                end
            end
            S_RWAIT: begin
                if (rwait_cnt_q == '0) begin
                    state_d     = S_EXEC;
                    exec_cnt_d  = exec_load(req_q.delay);
                end else begin
                    rwait_cnt_d = rwait_cnt_q - RWAIT_W'(1);
                end
            end
            S_EXEC: begin
                if (exec_cnt_q == '0) begin
                    state_d    = S_WR;
                end else begin
                    exec_cnt_d = exec_cnt_q - MAX_DELAY_LG2'(1);
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the upcoming state
        req_ready_d    = (state_d == S_IDLE);
        busy_d         = (state_d != S_IDLE);
        sram_ren_d     = (state_d == S_RD)   ? req_d.rvalid  : '0;
        sram_raddr_d   = (state_d == S_RD)   ? req_d.raddr   : '0;
        exec_start_d   = (state_d == S_EXEC) && (state_q != S_EXEC);
        exec_op_func_d = (state_d == S_EXEC) ? req_d.op_func : '0;
        exec_opcode_d  = (state_d == S_EXEC) ? req_d.opcode  : '0;
        sram_wen_d     = (state_d == S_WR);
        sram_waddr_d   = (state_d == S_WR)   ? req_d.waddr   : '0;
        done_d         = (state_d == S_WR);
    end

    // Operands are only presented in the launch cycle, masked by rvalid
    always_comb begin
        exec_operand = '0;
        if (exec_start_q) begin
            for (int unsigned k = 0; k < SRAM_R_PORT_CNT; k++) begin
                if (req_q.rvalid[k]) begin
                    exec_operand[k*DATA_W +: DATA_W] = sram_rdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign sram_wdata    = sram_wen_q ? exec_result : '0;

    assign req.req_ready = req_ready_q;
    assign busy          = busy_q;
    assign sram_ren      = sram_ren_q;
    assign sram_raddr    = sram_raddr_q;
    assign exec_start    = exec_start_q;
    assign exec_op_func  = exec_op_func_q;
    assign exec_opcode   = exec_opcode_q;
    assign sram_wen      = sram_wen_q;
    assign sram_waddr    = sram_waddr_q;
    assign done          = done_q;

endmodule

// File: doc/vpu_issue_ctrl.md
Name: vpu_issue_ctrl

Overview:
- Consumer (device) end of the decoded-request interface driven by the VPU decoder.
- Accepts one decoded request at a time and drives the SRAM read ports for the active source operands.
- Launches the execution lane with op_func/opcode and the read data, holds for the decoded fixed delay, then issues one SRAM write of the lane result to waddr.
- Single-issue, non-pipelined sequencer between the decoder and the SRAM and execution datapath.

Parameters:
- SRAM_R_PORT_CNT, 3, number of SRAM read ports / source operands.
- ADDR_W, 8, SRAM address width.
- DATA_W, 256, SRAM row width.
- MAX_DELAY_LG2, 4, width of the decoded delay field.
- OPCODE_W, 5, opcode width.
- OPFUNC_W, 16, packed width of the exec request (op_func).
- SRAM_RD_LAT, 1, SRAM read latency in cycles, from ren to rdata valid (must be ≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  decoded request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_raddr  in  SRAM_R_PORT_CNT*ADDR_W  source addresses, port k at bits [k*ADDR_W +: ADDR_W].
- req_rvalid  in  SRAM_R_PORT_CNT  active-source mask.
- req_waddr  in  ADDR_W  destination address.
- req_delay  in  MAX_DELAY_LG2  execution latency in cycles.
- req_op_func  in  OPFUNC_W  packed exec request.
- req_opcode  in  OPCODE_W  opcode; 0 means NOP.
- sram_ren  out  SRAM_R_PORT_CNT  per-port read enable.
- sram_raddr  out  SRAM_R_PORT_CNT*ADDR_W  read addresses.
- sram_rdata  in  SRAM_R_PORT_CNT*DATA_W  read data.
- exec_start  out  1  one-cycle launch pulse to the execution lane.
- exec_op_func  out  OPFUNC_W  latched op_func.
- exec_opcode  out  OPCODE_W  latched opcode.
- exec_operand  out  SRAM_R_PORT_CNT*DATA_W  operands.
- exec_result  in  DATA_W  lane result.
- sram_wen  out  1  write enable.
- sram_waddr  out  ADDR_W  write address.
- sram_wdata  out  DATA_W  write data.
- busy  out  1  request in flight.
- done  out  1  one-cycle completion pulse, coincident with sram_wen.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and all latched request fields clear to 0.
  - Outputs: req_ready=1, busy=0, and every other output 0.
  - Reset mid-operation aborts the request; no write is issued.
- States are IDLE, RD, RWAIT, EXEC, WR.
- IDLE:
  - req_ready=1; this is the only state with req_ready high.
  - On handshake at edge T, latch all req_* fields.
  - opcode==0: drop the request and stay in IDLE; no reads, writes or pulses.
  - rvalid==0 (non-NOP): go to EXEC.
  - Otherwise: go to RD.
- RD (cycle T+1):
  - sram_ren = latched rvalid; sram_raddr = latched raddr, also driven while ren=0.
  - Next state: RWAIT if SRAM_RD_LAT>1, else EXEC.
- RWAIT:
  - Lasts SRAM_RD_LAT-1 cycles; ren=0.
  - Then go to EXEC.
- EXEC:
  - First cycle: exec_start=1; exec_operand[k] = sram_rdata[k] if rvalid[k], else 0.
  - exec_operand is 0 outside that first cycle. exec_op_func and exec_opcode hold the latched values for the whole of EXEC.
  - Lasts D = max(req_delay,1) cycles (delay 0 is treated as 1), counted by a down-counter loaded at EXEC entry.
  - Then go to WR.
- WR:
  - Single cycle: sram_wen=1, sram_waddr = latched waddr, sram_wdata = exec_result sampled this cycle, done=1.
  - Next state: IDLE.
- busy = (state != IDLE).
- Latency for non-NOP requests, handshake at T:
  - rvalid≠0: exec_start at T+1+SRAM_RD_LAT; write at T+1+SRAM_RD_LAT+D; req_ready high again at T+2+SRAM_RD_LAT+D.
  - rvalid==0: exec_start at T+1; write at T+1+D.
- req_valid while busy is ignored (req_ready=0); the request must be held by the source.
- Back-to-back requests: the next handshake can occur in the first IDLE cycle after WR; there is no bubble beyond that cycle.
- Input fields are sampled only at the handshake. Later changes on req_* have no effect.

Test Plan:
- Reset release, then a 3-operand request (rvalid=3'b111, raddr={0x12,0x11,0x10}, waddr=0x20, delay=2), SRAM_RD_LAT=1, handshake at T:
  - sram_ren=3'b111 with addresses 0x10/0x11/0x12 at T+1.
  - exec_start at T+2 with all three operands.
  - sram_wen with waddr=0x20 and wdata=exec_result at T+4; done at T+4.
  - req_ready=1 at T+5.
- 1-operand request (rvalid=3'b001, delay=0) → ren=3'b001 only; operands 1 and 2 are zero; EXEC lasts 1 cycle; write at T+3.
- opcode=0 with req_valid=1 → req_ready stays 1; no ren, exec_start, wen or done; busy stays 0.
- Two requests held back-to-back (delay=2 each) → second handshake exactly at T+5; second write at T+9.
- rst asserted during EXEC → all outputs 0 immediately (asynchronously); no write; after rst drops req_ready=1 and a new request completes normally.
- SRAM_RD_LAT=3, rvalid=3'b011, delay=4 → ren at T+1 only; exec_start at T+4; wen at T+8.
